// File: rtl/lux_pwm.sv
// Ambient-light to LED PWM: periodic sampling, box averaging, optional inversion,
// and an 8-bit PWM whose duty only changes at period boundaries.
module lux_pwm #(
    parameter int unsigned SAMPLE_PERIOD = 50000,
    parameter int unsigned AVG_LOG2      = 3,
    parameter int unsigned PRESCALE      = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       invert,
    output logic       pwm,
    output logic [7:0] duty,
    output logic       avg_stb
);

    localparam int unsigned ACC_W    = 8 + AVG_LOG2;
    localparam logic [15:0] TMR_LAST = 16'(SAMPLE_PERIOD - 1);
    localparam logic [7:0]  PRE_LAST = 8'(PRESCALE);

    logic [15:0]      tmr_q, tmr_d;
    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic [7:0]       avg;
    logic [7:0]       level_q, level_d;
    logic [7:0]       pre_q, pre_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [7:0]       duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic             stb_q, stb_d;
    logic             sample;
    logic             final_smp;
    logic             tick;

    // The sample counter wraps to 0 on its own after the final sample.
    if (AVG_LOG2 > 0) begin : g_cnt
        logic [AVG_LOG2-1:0] scnt_q, scnt_d;

        always_comb begin
            scnt_d = scnt_q;
            if (sample) scnt_d = scnt_q + AVG_LOG2'(1);
        end

        always_ff @(posedge clk) begin
            if (rst) scnt_q <= '0;
            else     scnt_q <= scnt_d;
        end

        assign final_smp = &scnt_q;
    end else begin : g_nocnt
        assign final_smp = 1'b1;
    end

    always_comb begin
        sample = (tmr_q == TMR_LAST);
        tmr_d  = sample ? '0 : tmr_q + 16'd1;

        // Width 8+AVG_LOG2 holds 2^AVG_LOG2 * 255, so the sum never overflows.
        sum     = acc_q + ACC_W'(data);
        avg     = 8'(sum >> AVG_LOG2);
        acc_d   = acc_q;
        level_d = level_q;
        stb_d   = 1'b0;
        if (sample) begin
            if (final_smp) begin
                acc_d   = '0;
                level_d = invert ? 8'd255 - avg : avg;
                stb_d   = 1'b1;
            end else begin
                acc_d = sum;
            end
        end

        tick      = (pre_q == PRE_LAST);
        pre_d     = tick ? '0 : pre_q + 8'd1;
        pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;

        // level_q is the pre-update value, so a same-cycle new level waits a period.
        duty_d = (tick && pwm_cnt_q == 8'hFF) ? level_q : duty_q;
        pwm_d  = (pwm_cnt_q < duty_q);
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q     <= '0;
            acc_q     <= '0;
            level_q   <= '0;
            pre_q     <= '0;
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            pwm_q     <= 1'b0;
            stb_q     <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            acc_q     <= acc_d;
            level_q   <= level_d;
            pre_q     <= pre_d;
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
            stb_q     <= stb_d;
        end
    end

    assign pwm     = pwm_q;
    assign duty    = duty_q;
    assign avg_stb = stb_q;

endmodule

// File: tb/tb_lux_pwm.sv
// Self-checking bench for lux_pwm: two instances (PRESCALE 0 and 3) compared each
// cycle against a reference model derived from the elapsed clock count since reset.
module tb_lux_pwm;

    localparam int SP = 4;
    localparam int AL = 2;
    localparam int PRE [2] = '{0, 3};

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       invert;
    logic       pwm0, pwm1, stb0, stb1;
    logic [7:0] duty0, duty1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model state: mn counts clock edges since the last reset edge.
    int         mn    [2];
    int         msum  [2];
    int         mk    [2];
    logic [7:0] mlevel[2];
    logic [7:0] mduty [2];
    logic       mpwm  [2];
    logic       mstb  [2];

    lux_pwm #(.SAMPLE_PERIOD(SP), .AVG_LOG2(AL), .PRESCALE(0)) u0 (
        .clk(clk), .rst(rst), .data(data), .invert(invert),
        .pwm(pwm0), .duty(duty0), .avg_stb(stb0)
    );

    lux_pwm #(.SAMPLE_PERIOD(SP), .AVG_LOG2(AL), .PRESCALE(3)) u1 (
        .clk(clk), .rst(rst), .data(data), .invert(invert),
        .pwm(pwm1), .duty(duty1), .avg_stb(stb1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Everything follows from the edge count: the timer is n mod SP, the PWM counter
    // is (n / (PRESCALE+1)) mod 256, and a group of 2^AL samples is summed then shifted.
    task automatic model_step(input int i, input logic r, input logic [7:0] d, input logic inv);
        int pn, pp1, cnt_prev, avg;
        if (r) begin
            mn[i] = 0; msum[i] = 0; mk[i] = 0;
            mlevel[i] = 8'h00; mduty[i] = 8'h00; mpwm[i] = 1'b0; mstb[i] = 1'b0;
        end else begin
            pn       = mn[i];
            pp1      = PRE[i] + 1;
            cnt_prev = (pn / pp1) % 256;
            mpwm[i]  = (cnt_prev < int'(mduty[i]));
            if ((pn % pp1) == pp1 - 1 && cnt_prev == 255) mduty[i] = mlevel[i];
            mstb[i] = 1'b0;
            if ((pn % SP) == SP - 1) begin
                msum[i] += int'(d);
                mk[i]++;
                if (mk[i] == (1 << AL)) begin
                    avg       = msum[i] >> AL;
                    mlevel[i] = inv ? 8'(255 - avg) : 8'(avg);
                    msum[i]   = 0;
                    mk[i]     = 0;
                    mstb[i]   = 1'b1;
                end
            end
            mn[i] = pn + 1;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst, data, invert);
        model_step(1, rst, data, invert);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pwm0",  pwm0,  mpwm[0]);
            check("duty0", duty0, mduty[0]);
            check("stb0",  stb0,  mstb[0]);
            check("pwm1",  pwm1,  mpwm[1]);
            check("duty1", duty1, mduty[1]);
            check("stb1",  stb1,  mstb[1]);
            check("cnt1",  u1.pwm_cnt_q, (mn[1] / 4) % 256);
        end
    end

    task automatic wait_n(input int target);
        int guard = 0;
        while (mn[0] != target && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) check("wait_timeout", mn[0], target);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic count_high(input int sel, input int start, input int len, output int h);
        h = 0;
        wait_n(start);
        repeat (len) begin
            h += (sel == 1) ? int'(pwm1) : int'(pwm0);
            @(negedge clk);
        end
    endtask

    initial begin
        int h;
        rst = 1'b1; data = 8'h00; invert = 1'b0;
        repeat (2) @(negedge clk);
        data = 8'h80;
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state and first average of a constant 0x80.
        check("rst_duty", duty0, 8'h00);
        check("rst_pwm", pwm0, 1'b0);
        check("rst_stb", stb0, 1'b0);
        wait_n(15); check("stb_early", stb0, 1'b0);
        wait_n(16); check("stb_pulse", stb0, 1'b1); check("level_80", u0.level_q, 8'h80);
        wait_n(17); check("stb_one_clk", stb0, 1'b0);
        wait_n(255); check("duty_before_bnd", duty0, 8'h00);
        wait_n(256); check("duty_80", duty0, 8'h80);
        count_high(0, 258, 256, h); check("high_128", h, 128);

        // Truncating average of a mixed group, then a full-scale group.
        data = 8'h10;
        pulse_rst();
        wait_n(4);  data = 8'h20;
        wait_n(8);  data = 8'h30;
        wait_n(12); data = 8'h41;
        wait_n(16); check("level_28", u0.level_q, 8'h28); data = 8'hFF;
        wait_n(32); check("level_ff", u0.level_q, 8'hFF);

        // Inverted dark room gives full duty; inverted bright room gives zero.
        data = 8'h00; invert = 1'b1;
        pulse_rst();
        wait_n(16); check("inv_level_ff", u0.level_q, 8'hFF);
        wait_n(256); check("inv_duty_ff", duty0, 8'hFF);
        count_high(0, 258, 256, h); check("high_255", h, 255);
        data = 8'hFF;
        count_high(0, 770, 256, h); check("high_0", h, 0);
        check("inv_duty_0", duty0, 8'h00);

        // Final sample coincides with the period boundary: old level is loaded.
        data = 8'h80; invert = 1'b0;
        pulse_rst();
        wait_n(240); data = 8'h20;
        wait_n(256); check("coll_duty_old", duty0, 8'h80); check("coll_level_new", u0.level_q, 8'h20);
        wait_n(511); check("coll_duty_hold", duty0, 8'h80);
        wait_n(512); check("coll_duty_new", duty0, 8'h20);

        // Reset after two of four 0xFF samples must discard the partial sum.
        data = 8'h80;
        pulse_rst();
        wait_n(256); check("mid_duty_80", duty0, 8'h80); data = 8'hFF;
        wait_n(264);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        data = 8'h40;
        check("mid_rst_duty", duty0, 8'h00);
        check("mid_rst_pwm", pwm0, 1'b0);
        wait_n(16); check("mid_level_40", u0.level_q, 8'h40); check("mid_stb", stb0, 1'b1);

        // Prescaled instance: counter advances every 4th clock, duty 1 is 4 clocks high.
        data = 8'h01;
        pulse_rst();
        wait_n(4); check("pre_cnt_4", u1.pwm_cnt_q, 8'd1);
        wait_n(7); check("pre_cnt_7", u1.pwm_cnt_q, 8'd1);
        wait_n(8); check("pre_cnt_8", u1.pwm_cnt_q, 8'd2);
        wait_n(1024); check("pre_duty_1", duty1, 8'h01);
        count_high(1, 1025, 1024, h); check("pre_high_4", h, 4);

        // Random data, invert toggles and occasional resets against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) data = 8'($urandom);
            if ($urandom_range(0, 31) == 0) invert = ~invert;
            rst = ($urandom_range(0, 799) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
